// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: synchronizes bclk/lrck/dat, deserializes one word per LR phase, queues {chan, word}.
// Framing: left-justified by default; define AUD_RX_I2S_MODE_EN for I2S (MSB one bit after the LR edge).
module audio_adc_rx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    aud_bclk,
    input  logic                    aud_lrck,
    input  logic                    aud_dat,
    input  logic [1:0]              channel_sel,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic                    out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    input  logic                    ovf_clear,
    output logic [1:0]              dbg_state
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    logic bclk_s1_q, bclk_s2_q, bclk_prev_q;
    logic lrck_s1_q, lrck_s2_q;
    logic dat_s1_q, dat_s2_q;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic                    chan_q;
    logic                    lrck_last_q;
    logic                    push_q;

    logic [SAMPLE_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]             wr_q, rd_q, wr_d, rd_d;
    logic                    ovf_q;

    logic bit_evt, frame_edge, keep;
    logic empty, full, pop, wr_en, ovf_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            dat_s1_q    <= 1'b0;
            dat_s2_q    <= 1'b0;
        end else begin
            bclk_s1_q   <= aud_bclk;
            bclk_s2_q   <= bclk_s1_q;
            bclk_prev_q <= bclk_s2_q;
            lrck_s1_q   <= aud_lrck;
            lrck_s2_q   <= lrck_s1_q;
            dat_s1_q    <= aud_dat;
            dat_s2_q    <= dat_s1_q;
        end
    end

    assign bit_evt    = bclk_s2_q && !bclk_prev_q;
    assign frame_edge = bit_evt && (lrck_s2_q != lrck_last_q);
    assign keep       = chan_q ? channel_sel[1] : channel_sel[0];

    // A frame edge restarts capture from any state, dropping any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            chan_q      <= 1'b0;
            lrck_last_q <= 1'b0;
            push_q      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (bit_evt) begin
                lrck_last_q <= lrck_s2_q;
                if (frame_edge) begin
                    chan_q <= lrck_s2_q;
`ifdef AUD_RX_I2S_MODE_EN
                    state_q <= DELAY;
                    cnt_q   <= '0;
`else
                    state_q <= SHIFT;
                    cnt_q   <= CW'(1);
                    shift_q <= {shift_q[SAMPLE_WIDTH-2:0], dat_s2_q};
`endif
                end else begin
                    case (state_q)
                        DELAY: begin
                            state_q <= SHIFT;
                            cnt_q   <= CW'(1);
                            shift_q <= {shift_q[SAMPLE_WIDTH-2:0], dat_s2_q};
                        end
                        SHIFT: begin
                            shift_q <= {shift_q[SAMPLE_WIDTH-2:0], dat_s2_q};
                            if (cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
                                state_q <= HOLD;
                                cnt_q   <= '0;
                                push_q  <= keep;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign dbg_state = state_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && out_ready;
    assign wr_en   = push_q && (!full || pop);
    assign ovf_evt = push_q && full && !pop;
    assign wr_d    = wr_en ? wr_q + (AW+1)'(1) : wr_q;
    assign rd_d    = pop ? rd_q + (AW+1)'(1) : rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= {chan_q, shift_q};
            end
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (ovf_clear) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_valid = !empty;
    assign out_data  = mem_q[rd_q[AW-1:0]][SAMPLE_WIDTH-1:0];
    assign out_chan  = mem_q[rd_q[AW-1:0]][SAMPLE_WIDTH];
    assign overflow  = ovf_q;

endmodule
